// File: rtl/rect_hit_detector_pkg.sv
// rtl/rect_hit_detector_pkg.sv - shared coordinate/size defaults and packed-field helpers
package rect_hit_detector_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int SIZE_W_DEF  = 6;
    localparam int N_RECT_DEF  = 4;

    // Low bit of channel idx inside a bus packed as idx*width +: width.
    function automatic int field_lo(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rect_contain_stage.sv
// rtl/rect_contain_stage.sv - per-rectangle X/Y containment compare, registered (pipeline stage 1)
module rect_contain_stage
    import rect_hit_detector_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int SIZE_W  = SIZE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] rect_x,
    input  logic [COORD_W-1:0] rect_y,
    input  logic [SIZE_W-1:0]  rect_w,
    input  logic [SIZE_W-1:0]  rect_h,
    input  logic               rect_en,
    output logic               x_hit,
    output logic               y_hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             x_in;
    logic             y_in;

    // Far edges carry one extra bit so a rectangle near the right/bottom edge never wraps to 0.
    always_comb begin
        x_end = {1'b0, rect_x} + (COORD_W+1)'(rect_w);
        y_end = {1'b0, rect_y} + (COORD_W+1)'(rect_h);
        x_in  = rect_en && (pix_x >= rect_x) && ({1'b0, pix_x} < x_end);
        y_in  = rect_en && (pix_y >= rect_y) && ({1'b0, pix_y} < y_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_hit <= 1'b0;
            y_hit <= 1'b0;
        end else begin
            x_hit <= x_in;
            y_hit <= y_in;
        end
    end

endmodule

// File: rtl/rect_hit_detector.sv
// rtl/rect_hit_detector.sv - two-stage pixel-in-rectangle detector with per-frame player collision summary
module rect_hit_detector
    import rect_hit_detector_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int SIZE_W  = SIZE_W_DEF,
    parameter int N_RECT  = N_RECT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [COORD_W-1:0]            pix_x,
    input  logic [COORD_W-1:0]            pix_y,
    input  logic [N_RECT*COORD_W-1:0]     rect_x,
    input  logic [N_RECT*COORD_W-1:0]     rect_y,
    input  logic [N_RECT*SIZE_W-1:0]      rect_w,
    input  logic [N_RECT*SIZE_W-1:0]      rect_h,
    input  logic [N_RECT-1:0]             rect_en,
    output logic                          hit_valid,
    output logic [N_RECT-1:0]             hit_mask,
    output logic                          hit_any,
    output logic [idx_width(N_RECT)-1:0]  hit_idx,
    output logic                          frame_done,
    output logic                          collide_last,
    output logic [N_RECT-1:0]             collide_mask
);

    localparam int IDX_W = idx_width(N_RECT);
    localparam logic [N_RECT-1:0] PLAYER_BIT = N_RECT'(1);

    logic [N_RECT*COORD_W-1:0] sh_x;
    logic [N_RECT*COORD_W-1:0] sh_y;
    logic [N_RECT*SIZE_W-1:0]  sh_w;
    logic [N_RECT*SIZE_W-1:0]  sh_h;
    logic [N_RECT-1:0]         sh_en;

    logic                      valid_s1;
    logic                      fs_s1;
    logic [N_RECT-1:0]         x_hit;
    logic [N_RECT-1:0]         y_hit;

    logic [N_RECT-1:0]         mask_c;
    logic [IDX_W-1:0]          idx_c;
    logic [N_RECT-1:0]         acc;
    logic [N_RECT-1:0]         acc_hit;

    // Geometry is frozen per frame so mid-frame writes never tear a rectangle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_w  <= '0;
            sh_h  <= '0;
            sh_en <= '0;
        end else if (frame_start) begin
            sh_x  <= rect_x;
            sh_y  <= rect_y;
            sh_w  <= rect_w;
            sh_h  <= rect_h;
            sh_en <= rect_en;
        end
    end

    // The frame_start cycle's pixel is dropped; the frame marker rides along with the pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1 <= 1'b0;
            fs_s1    <= 1'b0;
        end else begin
            valid_s1 <= pix_valid && !frame_start;
            fs_s1    <= frame_start;
        end
    end

    for (genvar k = 0; k < N_RECT; k++) begin : g_stage
        rect_contain_stage #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .pix_x   (pix_x),
            .pix_y   (pix_y),
            .rect_x  (sh_x[field_lo(k, COORD_W) +: COORD_W]),
            .rect_y  (sh_y[field_lo(k, COORD_W) +: COORD_W]),
            .rect_w  (sh_w[field_lo(k, SIZE_W) +: SIZE_W]),
            .rect_h  (sh_h[field_lo(k, SIZE_W) +: SIZE_W]),
            .rect_en (sh_en[k]),
            .x_hit   (x_hit[k]),
            .y_hit   (y_hit[k])
        );
    end

    always_comb begin
        mask_c = valid_s1 ? (x_hit & y_hit) : '0;
        idx_c  = '0;
        for (int k = N_RECT - 1; k >= 0; k--) begin
            if (mask_c[k]) idx_c = IDX_W'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid <= 1'b0;
            hit_mask  <= '0;
            hit_any   <= 1'b0;
            hit_idx   <= '0;
        end else begin
            hit_valid <= valid_s1;
            hit_mask  <= mask_c;
            hit_any   <= |mask_c;
            hit_idx   <= idx_c;
        end
    end

    always_comb begin
        acc_hit = (hit_valid && hit_mask[0]) ? (hit_mask & ~PLAYER_BIT) : '0;
    end

    // On the frame boundary the old total is published and a coincident hit seeds the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            frame_done   <= 1'b0;
            collide_last <= 1'b0;
            collide_mask <= '0;
        end else begin
            frame_done <= fs_s1;
            if (fs_s1) begin
                collide_mask <= acc;
                collide_last <= |acc;
                acc          <= acc_hit;
            end else begin
                acc          <= acc | acc_hit;
            end
        end
    end

endmodule

// File: tb/tb_rect_hit_detector.sv
// tb/tb_rect_hit_detector.sv - directed self-checking bench for rect_hit_detector
`timescale 1ns/1ps
module tb_rect_hit_detector;

    localparam int CW = 10;
    localparam int SW = 6;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic              pix_valid;
    logic [CW-1:0]     pix_x;
    logic [CW-1:0]     pix_y;
    logic [NR*CW-1:0]  rect_x;
    logic [NR*CW-1:0]  rect_y;
    logic [NR*SW-1:0]  rect_w;
    logic [NR*SW-1:0]  rect_h;
    logic [NR-1:0]     rect_en;
    logic              hit_valid;
    logic [NR-1:0]     hit_mask;
    logic              hit_any;
    logic [1:0]        hit_idx;
    logic              frame_done;
    logic              collide_last;
    logic [NR-1:0]     collide_mask;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rect_hit_detector #(.COORD_W(CW), .SIZE_W(SW), .N_RECT(NR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .rect_x       (rect_x),
        .rect_y       (rect_y),
        .rect_w       (rect_w),
        .rect_h       (rect_h),
        .rect_en      (rect_en),
        .hit_valid    (hit_valid),
        .hit_mask     (hit_mask),
        .hit_any      (hit_any),
        .hit_idx      (hit_idx),
        .frame_done   (frame_done),
        .collide_last (collide_last),
        .collide_mask (collide_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rect(input int k, input int x, input int y, input int w, input int h, input bit en);
        rect_x[k*CW +: CW] = CW'(x);
        rect_y[k*CW +: CW] = CW'(y);
        rect_w[k*SW +: SW] = SW'(w);
        rect_h[k*SW +: SW] = SW'(h);
        rect_en[k]         = en;
    endtask

    task automatic probe(input string tag, input int x, input int y, input int exp_mask, input int exp_idx);
        pix_x = CW'(x);
        pix_y = CW'(y);
        pix_valid = 1'b1;
        step;
        pix_valid = 1'b0;
        check({tag, "/lat1"}, hit_valid, 0);
        step;
        check({tag, "/valid"}, hit_valid, 1);
        check({tag, "/mask"}, hit_mask, exp_mask);
        check({tag, "/any"}, hit_any, (exp_mask != 0) ? 1 : 0);
        check({tag, "/idx"}, hit_idx, exp_idx);
    endtask

    task automatic frame(input string tag, input int exp_last, input int exp_cmask);
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        check({tag, "/done_early"}, frame_done, 0);
        step;
        check({tag, "/done"}, frame_done, 1);
        check({tag, "/last"}, collide_last, exp_last);
        check({tag, "/cmask"}, collide_mask, exp_cmask);
        step;
        check({tag, "/done_pulse"}, frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_x = '0;
        pix_y = '0;
        rect_x = '0;
        rect_y = '0;
        rect_w = '0;
        rect_h = '0;
        rect_en = '0;
        step;
        step;
        check("rst/valid", hit_valid, 0);
        check("rst/mask", hit_mask, 0);
        check("rst/done", frame_done, 0);
        check("rst/last", collide_last, 0);
        check("rst/cmask", collide_mask, 0);
        rst_n = 1'b1;

        set_rect(0, 100, 200, 16, 16, 1);
        set_rect(1, 1000, 0, 40, 8, 1);
        set_rect(2, 5, 5, 0, 4, 1);
        set_rect(3, 0, 0, 10, 10, 0);
        frame("first", 0, 0);

        probe("in_edge", 115, 215, 'b0001, 0);
        probe("out_x", 116, 215, 'b0000, 0);
        probe("corner", 100, 200, 'b0001, 0);
        probe("left", 99, 200, 'b0000, 0);
        probe("out_y", 115, 216, 'b0000, 0);
        probe("nowrap_hit", 1023, 3, 'b0010, 1);
        probe("nowrap_miss", 0, 3, 'b0000, 0);
        probe("r1_bottom", 1000, 7, 'b0010, 1);
        probe("r1_below", 1000, 8, 'b0000, 0);
        probe("w_zero", 5, 5, 'b0000, 0);
        probe("dis3", 2, 2, 'b0000, 0);

        probe("shadow_old", 105, 205, 'b0001, 0);
        set_rect(0, 300, 200, 16, 16, 1);
        probe("shadow_hold", 105, 205, 'b0001, 0);
        probe("shadow_new_early", 305, 205, 'b0000, 0);
        frame("shadow_f", 0, 0);
        probe("shadow_new", 305, 205, 'b0001, 0);
        probe("shadow_old_gone", 105, 205, 'b0000, 0);

        set_rect(0, 50, 50, 10, 10, 1);
        set_rect(1, 0, 0, 0, 0, 0);
        set_rect(2, 55, 55, 10, 10, 1);
        frame("ovl_load", 0, 0);
        probe("ovl_both", 57, 57, 'b0101, 0);
        probe("ovl_obst", 62, 62, 'b0100, 2);
        probe("ovl_player", 52, 52, 'b0001, 0);
        for (int y = 40; y < 80; y++) begin
            for (int x = 40; x < 80; x++) begin
                pix_x = CW'(x);
                pix_y = CW'(y);
                pix_valid = 1'b1;
                step;
            end
        end
        pix_valid = 1'b0;
        step;
        step;
        frame("ovl_report", 1, 'b0100);
        frame("clean", 0, 0);

        pix_x = CW'(56);
        pix_y = CW'(56);
        pix_valid = 1'b1;
        step;
        pix_valid = 1'b0;
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        check("coinc/valid", hit_valid, 1);
        check("coinc/mask", hit_mask, 'b0101);
        step;
        check("coinc/done", frame_done, 1);
        check("coinc/last", collide_last, 0);
        check("coinc/cmask", collide_mask, 0);
        step;

        frame_start = 1'b1;
        pix_valid = 1'b1;
        step;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        step;
        check("carry/done", frame_done, 1);
        check("carry/last", collide_last, 1);
        check("carry/cmask", collide_mask, 'b0100);
        check("drop/valid", hit_valid, 0);
        step;
        frame("drop_none", 0, 0);

        frame_start = 1'b1;
        step;
        step;
        frame_start = 1'b0;
        check("b2b/done1", frame_done, 1);
        step;
        check("b2b/done2", frame_done, 1);
        step;
        check("b2b/done3", frame_done, 0);

        frame("rstmid_load", 0, 0);
        pix_x = CW'(56);
        pix_y = CW'(56);
        pix_valid = 1'b1;
        step;
        step;
        step;
        check("rstmid/pre_valid", hit_valid, 1);
        check("rstmid/pre_mask", hit_mask, 'b0101);
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        step;
        check("rstmid/pre_done", frame_done, 1);
        check("rstmid/pre_last", collide_last, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid/valid", hit_valid, 0);
        check("rstmid/mask", hit_mask, 0);
        check("rstmid/any", hit_any, 0);
        check("rstmid/done", frame_done, 0);
        check("rstmid/last", collide_last, 0);
        check("rstmid/cmask", collide_mask, 0);
        step;
        rst_n = 1'b1;
        step;
        check("rel/valid1", hit_valid, 0);
        step;
        check("rel/valid2", hit_valid, 1);
        check("rel/mask", hit_mask, 0);
        check("rel/done", frame_done, 0);
        pix_valid = 1'b0;
        step;
        step;
        check("rel/idle", hit_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
